puf_auth_ctrl: RTL and testbench
================================

PUF_AUTH_CTRL -- requirements
Module: puf_auth_ctrl

Interface
REQ-001 SHALL have parameter CMD_CHAL, default 8'h01: command byte sent to request a challenge.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h55: status byte sent on a valid response.
REQ-003 SHALL have parameter NAK_BYTE, default 8'hAA: status byte sent on an invalid response or a timeout.
REQ-004 SHALL have parameter MEM_BASE, default 8'h00: first SPRAM address for the stored response.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: maximum number of cycles to wait for puf_done.
REQ-006 Ports (name  direction  width  meaning):
  clk  in  1  single clock; all logic on its rising edge.
  n_rst  in  1  asynchronous, active-low reset.
  go  in  1  starts one authentication sequence.
  busy  out  1  high whenever state != IDLE.
  pass  out  1  one-cycle pulse: sequence finished with ACK.
  fail  out  1  one-cycle pulse: sequence finished with NAK.
  tx_byte  out  8  byte to the SPI master.
  tx_dv  out  1  one-cycle transmit strobe to the SPI master.
  tx_ready  in  1  SPI master idle.
  rx_dv  in  1  one-cycle strobe: rx_byte is valid.
  rx_byte  in  8  byte received by the SPI master.
  puf_start  out  1  one-cycle PUF start pulse.
  puf_challenge  out  8  registered challenge.
  puf_response  in  256  PUF response.
  puf_done  in  1  PUF finished.
  val_start  out  1  response validator enable.
  val_valid  in  1  validator result.
  mem_addr  out  8  SPRAM address.
  mem_data  out  8  SPRAM write data.
  mem_we  out  1  SPRAM write enable.

Function
REQ-007 The FSM SHALL have these states: IDLE, SEND_CMD, SEND_DUMMY, PUF_RUN, VALIDATE, STORE, SEND_STAT, WAIT_STAT.
REQ-008 In IDLE, go=1 SHALL cause a transition to SEND_CMD; go SHALL be ignored in every other state.
REQ-009 tx_dv SHALL pulse for exactly one cycle, and only in a cycle where tx_ready=1; while tx_ready=0 the FSM SHALL hold its state.
REQ-010 In SEND_CMD: tx_byte=CMD_CHAL, tx_dv pulsed; the rx_dv of this transfer SHALL be discarded; the FSM SHALL then go to SEND_DUMMY.
REQ-011 In SEND_DUMMY: tx_byte=8'h00, tx_dv pulsed; on the next rx_dv, puf_challenge<=rx_byte and the FSM SHALL go to PUF_RUN.
REQ-012 On entry to PUF_RUN, puf_start SHALL be high for one cycle; puf_done=1 SHALL cause a transition to VALIDATE.
REQ-013 In VALIDATE, val_start SHALL be held high; val_valid SHALL be sampled on the 2nd cycle in the state; 1 -> STORE, 0 -> SEND_STAT with NAK_BYTE.
REQ-014 STORE SHALL write 32 bytes, one per cycle, with mem_we=1: byte i = puf_response[8i+7:8i], mem_addr = (MEM_BASE+i) mod 256, i = 0..31; the address SHALL wrap past 8'hFF. After i=31 the FSM SHALL go to SEND_STAT with ACK_BYTE.
REQ-015 In SEND_STAT, the status byte SHALL be sent per REQ-009, then the FSM SHALL go to WAIT_STAT; the first tx_ready=1 seen after tx_ready has dropped SHALL return the FSM to IDLE, pulsing pass (ACK) or fail (NAK) in that cycle.
REQ-016 mem_we SHALL be 0 outside STORE; val_start SHALL be 0 outside VALIDATE.
REQ-017 If a transfer returns rx_dv=1 in the same cycle the FSM leaves a state, the state transition SHALL take priority and the byte SHALL be attributed to the state that issued the transfer.

Reset
REQ-018 n_rst=0 SHALL at any time, including mid-sequence, force state=IDLE and set to 0: all outputs, puf_challenge, the byte index and the timeout counter. No partial SPRAM write SHALL continue after reset.

Configuration
REQ-019 Macro PUF_AUTH_TIMEOUT_EN, when defined, SHALL count cycles in PUF_RUN; reaching TIMEOUT_CYC with puf_done=0 SHALL go to SEND_STAT with NAK_BYTE; puf_done=1 in the expiry cycle SHALL win. When undefined, there SHALL be no counter and PUF_RUN SHALL wait indefinitely.

Verification
REQ-020 go pulse, rx_byte 8'h3C on the 2nd transfer, puf_done after 10 cycles, val_valid=1 -> tx bytes 01,00,55; puf_challenge=3C; 32 writes at addresses 00..1F; one pass pulse.
REQ-021 Same as REQ-020 but val_valid=0 -> no mem_we; tx bytes 01,00,AA; one fail pulse.
REQ-022 MEM_BASE=8'hF0 with a valid response -> write addresses F0..FF then 00..0F.
REQ-023 With PUF_AUTH_TIMEOUT_EN, TIMEOUT_CYC=16 and puf_done never asserted -> NAK sent 16 cycles after puf_start; fail pulse. Without the macro -> FSM stays in PUF_RUN.
REQ-024 n_rst asserted at STORE byte 5 -> next cycle all outputs 0, busy=0; a new go then completes normally.
REQ-025 tx_ready held 0 for 20 cycles in SEND_CMD, and go pulsed while busy -> no tx_dv until tx_ready=1; the go is ignored.

Source files
------------

// File: rtl/puf_auth_ctrl.sv
// PUF challenge/response authentication sequencer: fetches a challenge over SPI, runs the PUF,
// validates and stores the response, then reports ACK/NAK. Optional PUF watchdog: PUF_AUTH_TIMEOUT_EN.
module puf_auth_ctrl #(
   parameter logic [7:0] CMD_CHAL    = 8'h01,
   parameter logic [7:0] ACK_BYTE    = 8'h55,
   parameter logic [7:0] NAK_BYTE    = 8'hAA,
   parameter logic [7:0] MEM_BASE    = 8'h00,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         go,
   output logic         busy,
   output logic         pass,
   output logic         fail,
   output logic [7:0]   tx_byte,
   output logic         tx_dv,
   input  logic         tx_ready,
   input  logic         rx_dv,
   input  logic [7:0]   rx_byte,
   output logic         puf_start,
   output logic [7:0]   puf_challenge,
   input  logic [255:0] puf_response,
   input  logic         puf_done,
   output logic         val_start,
   input  logic         val_valid,
   output logic [7:0]   mem_addr,
   output logic [7:0]   mem_data,
   output logic         mem_we,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_CMD, S_SEND_DUMMY, S_PUF_RUN,
      S_VALIDATE, S_STORE, S_SEND_STAT, S_WAIT_STAT
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_phase, w_phase_nxt;
   logic [4:0]  r_idx, w_idx_nxt;
   logic        r_ack, w_ack_nxt;
   logic [7:0]  r_chal, w_chal_nxt;
   logic        r_puf_start;
   logic        w_timeout;

`ifdef PUF_AUTH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   logic [CW-1:0] r_cnt;

   // r_cnt equals the number of completed cycles spent in PUF_RUN.
   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt <= '0;
      end else if (r_state == S_PUF_RUN && w_state_nxt == S_PUF_RUN) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // r_phase is a per-state sub-step: "byte sent" in the SPI states, "first cycle done"
   // in VALIDATE, "tx_ready has dropped" in WAIT_STAT. It clears on every state change.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_idx_nxt   = r_idx;
      w_ack_nxt   = r_ack;
      w_chal_nxt  = r_chal;
      tx_byte     = 8'h00;
      tx_dv       = 1'b0;
      val_start   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 8'h00;
      mem_data    = 8'h00;
      pass        = 1'b0;
      fail        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (go) w_state_nxt = S_SEND_CMD;
         end
         S_SEND_CMD: begin
            tx_byte = CMD_CHAL;
            if (!r_phase) begin
               if (tx_ready) begin
                  tx_dv       = 1'b1;
                  w_phase_nxt = 1'b1;
               end
            end else if (rx_dv) begin
               w_state_nxt = S_SEND_DUMMY;
            end
         end
         S_SEND_DUMMY: begin
            if (!r_phase) begin
               if (tx_ready) begin
                  tx_dv       = 1'b1;
                  w_phase_nxt = 1'b1;
               end
            end else if (rx_dv) begin
               w_chal_nxt  = rx_byte;
               w_state_nxt = S_PUF_RUN;
            end
         end
         S_PUF_RUN: begin
            if (puf_done) begin
               w_state_nxt = S_VALIDATE;
            end else if (w_timeout) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = S_SEND_STAT;
            end
         end
         S_VALIDATE: begin
            val_start = 1'b1;
            if (!r_phase) begin
               w_phase_nxt = 1'b1;
            end else if (val_valid) begin
               w_idx_nxt   = 5'd0;
               w_state_nxt = S_STORE;
            end else begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = S_SEND_STAT;
            end
         end
         S_STORE: begin
            mem_we   = 1'b1;
            mem_addr = MEM_BASE + {3'b000, r_idx};
            mem_data = puf_response[{r_idx, 3'b000} +: 8];
            if (r_idx == 5'd31) begin
               w_idx_nxt   = 5'd0;
               w_ack_nxt   = 1'b1;
               w_state_nxt = S_SEND_STAT;
            end else begin
               w_idx_nxt = r_idx + 5'd1;
            end
         end
         S_SEND_STAT: begin
            tx_byte = r_ack ? ACK_BYTE : NAK_BYTE;
            if (tx_ready) begin
               tx_dv       = 1'b1;
               w_state_nxt = S_WAIT_STAT;
            end
         end
         S_WAIT_STAT: begin
            if (!tx_ready) begin
               w_phase_nxt = 1'b1;
            end else if (r_phase) begin
               pass        = r_ack;
               fail        = !r_ack;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt != r_state) w_phase_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_phase     <= 1'b0;
         r_idx       <= 5'd0;
         r_ack       <= 1'b0;
         r_chal      <= 8'h00;
         r_puf_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_idx       <= w_idx_nxt;
         r_ack       <= w_ack_nxt;
         r_chal      <= w_chal_nxt;
         r_puf_start <= (w_state_nxt == S_PUF_RUN) && (r_state != S_PUF_RUN);
      end
   end

   assign busy          = (r_state != S_IDLE);
   assign puf_start     = r_puf_start;
   assign puf_challenge = r_chal;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Randomized bench for puf_auth_ctrl with an SPI/PUF environment model and a sequence-level reference.
module tb_puf_auth_ctrl;

   logic         clk = 1'b0;
   logic         n_rst, go, tx_ready, rx_dv, puf_done, val_valid;
   logic [7:0]   rx_byte;
   logic [255:0] puf_response;

   logic         a_busy, a_pass, a_fail, a_tx_dv, a_puf_start, a_val_start, a_mem_we;
   logic [7:0]   a_tx_byte, a_puf_challenge, a_mem_addr, a_mem_data;
   logic [2:0]   a_dbg_state;
   logic         b_busy, b_pass, b_fail, b_tx_dv, b_puf_start, b_val_start, b_mem_we;
   logic [7:0]   b_tx_byte, b_puf_challenge, b_mem_addr, b_mem_data;
   logic [2:0]   b_dbg_state;

   always #5 clk = ~clk;

   puf_auth_ctrl #(.MEM_BASE(8'h00), .TIMEOUT_CYC(16)) u_dut (
      .clk(clk), .n_rst(n_rst), .go(go), .busy(a_busy), .pass(a_pass), .fail(a_fail),
      .tx_byte(a_tx_byte), .tx_dv(a_tx_dv), .tx_ready(tx_ready), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .puf_start(a_puf_start), .puf_challenge(a_puf_challenge), .puf_response(puf_response),
      .puf_done(puf_done), .val_start(a_val_start), .val_valid(val_valid),
      .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_we(a_mem_we), .dbg_state(a_dbg_state)
   );

   puf_auth_ctrl #(.MEM_BASE(8'hF0), .TIMEOUT_CYC(16)) u_dut_f0 (
      .clk(clk), .n_rst(n_rst), .go(go), .busy(b_busy), .pass(b_pass), .fail(b_fail),
      .tx_byte(b_tx_byte), .tx_dv(b_tx_dv), .tx_ready(tx_ready), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .puf_start(b_puf_start), .puf_challenge(b_puf_challenge), .puf_response(puf_response),
      .puf_done(puf_done), .val_start(b_val_start), .val_valid(val_valid),
      .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_we(b_mem_we), .dbg_state(b_dbg_state)
   );

   int n_tests = 0;
   int n_errors = 0;

   // environment state
   int         cyc = 0;
   int         spi_cnt = -1;
   int         xfer_num = 0;
   int         hold_nr = 0;
   int         puf_delay = 10;
   int         puf_cnt = -1;
   logic       go_req = 1'b0;
   logic [7:0] chal_byte = 8'h00;

   // observation logs
   logic [7:0]  tx_log[$];
   logic [15:0] wr_a[$];
   logic [15:0] wr_b[$];
   int n_pass, n_fail, go_cyc, start_cyc, stat_cyc, first_tx_cyc, tx_dv_bad, vs_bad;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample outputs 1ns later.
   task automatic step();
      @(negedge clk);
      cyc++;
      go = go_req;
      if (go_req) go_cyc = cyc;
      go_req   = 1'b0;
      rx_dv    = 1'b0;
      puf_done = 1'b0;
      if (spi_cnt > 0) begin
         spi_cnt--;
         if (spi_cnt == 0) begin
            rx_dv    = 1'b1;
            rx_byte  = (xfer_num == 2) ? chal_byte : 8'($urandom);
            tx_ready = 1'b1;
            spi_cnt  = -1;
         end else begin
            tx_ready = 1'b0;
         end
      end else begin
         tx_ready = 1'b1;
      end
      if (hold_nr > 0) begin
         tx_ready = 1'b0;
         hold_nr--;
      end
      if (puf_cnt > 0) begin
         puf_cnt--;
         if (puf_cnt == 0) puf_done = 1'b1;
      end
      #1;
      if (a_tx_dv) begin
         if (!tx_ready) tx_dv_bad++;
         tx_log.push_back(a_tx_byte);
         xfer_num++;
         if (xfer_num == 1) first_tx_cyc = cyc;
         if (xfer_num == 3) stat_cyc = cyc;
         spi_cnt = $urandom_range(2, 5);
      end
      if (a_mem_we) wr_a.push_back({a_mem_addr, a_mem_data});
      if (b_mem_we) wr_b.push_back({b_mem_addr, b_mem_data});
      if (a_val_start && a_mem_we) vs_bad++;
      if (a_pass) n_pass++;
      if (a_fail) n_fail++;
      if (a_puf_start) begin
         puf_cnt   = puf_delay;
         start_cyc = cyc;
      end
   endtask

   task automatic do_reset();
      n_rst   = 1'b0;
      spi_cnt = -1;
      puf_cnt = -1;
      hold_nr = 0;
      go_req  = 1'b0;
      repeat (2) step();
      n_rst = 1'b1;
      step();
   endtask

   task automatic start_seq(input logic valid, input logic [7:0] chal, input int delay);
      val_valid    = valid;
      chal_byte    = chal;
      puf_delay    = delay;
      puf_response = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tx_log.delete();
      wr_a.delete();
      wr_b.delete();
      n_pass = 0; n_fail = 0; xfer_num = 0; tx_dv_bad = 0; vs_bad = 0;
      go_req = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 800 && (n_pass + n_fail) == 0; i++) step();
      if ((n_pass + n_fail) == 0) check_val({tag, "_done_timeout"}, 0, 1);
      repeat (3) step();
   endtask

   // Reference: a full sequence sends CMD, dummy, status; stores all 32 response bytes
   // from MEM_BASE upwards (8-bit wrap) only when the response is valid.
   task automatic check_seq(input string tag, input logic valid, input logic [7:0] chal);
      logic [7:0]  exp_q[$];
      logic [15:0] exp_a_q[$];
      logic [15:0] exp_b_q[$];
      logic [7:0]  ab, bb;
      exp_q = {8'h01, 8'h00, (valid ? 8'h55 : 8'hAA)};
      if (valid) begin
         for (int i = 0; i < 32; i++) begin
            ab = 8'(i);
            bb = 8'(8'hF0 + i);
            exp_a_q.push_back({ab, puf_response[i*8 +: 8]});
            exp_b_q.push_back({bb, puf_response[i*8 +: 8]});
         end
      end
      check_val({tag, "_tx_n"}, tx_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
         check_val($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_q[i]);
      check_val({tag, "_chal"}, a_puf_challenge, chal);
      check_val({tag, "_pass"}, n_pass, valid ? 1 : 0);
      check_val({tag, "_fail"}, n_fail, valid ? 0 : 1);
      check_val({tag, "_wr_n"}, wr_a.size(), exp_a_q.size());
      check_val({tag, "_wrb_n"}, wr_b.size(), exp_b_q.size());
      for (int i = 0; i < exp_a_q.size() && i < wr_a.size(); i++)
         check_val($sformatf("%s_wr%0d", tag, i), wr_a[i], exp_a_q[i]);
      for (int i = 0; i < exp_b_q.size() && i < wr_b.size(); i++)
         check_val($sformatf("%s_wrb%0d", tag, i), wr_b[i], exp_b_q[i]);
      check_val({tag, "_tx_gate"}, tx_dv_bad, 0);
      check_val({tag, "_vs_we"}, vs_bad, 0);
      check_val({tag, "_idle"}, a_busy, 0);
   endtask

   function automatic logic [31:0] outs_a();
      return {a_busy, a_pass, a_fail, a_tx_dv, a_puf_start, a_val_start, a_mem_we,
              a_tx_byte, a_puf_challenge, a_mem_addr, a_mem_data} != '0;
   endfunction

   initial begin
      logic [7:0] ch;
      logic       vv;
      int         g;
      n_rst = 1'b0; go = 1'b0; tx_ready = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
      puf_done = 1'b0; val_valid = 1'b0; puf_response = '0;
      do_reset();
      check_val("reset_outs", outs_a(), 0);

      // directed: valid and invalid responses
      start_seq(1'b1, 8'h3C, 10);
      wait_done("valid");
      check_seq("valid", 1'b1, 8'h3C);
      start_seq(1'b0, 8'h3C, 10);
      wait_done("invalid");
      check_seq("invalid", 1'b0, 8'h3C);

      // random sequences
      for (int r = 0; r < 6; r++) begin
         ch = 8'($urandom);
         vv = 1'($urandom_range(0, 1));
         start_seq(vv, ch, $urandom_range(1, 30));
         wait_done($sformatf("rnd%0d", r));
         check_seq($sformatf("rnd%0d", r), vv, ch);
      end

      // tx_ready held low in SEND_CMD; go while busy is ignored
      ch = 8'($urandom);
      start_seq(1'b1, ch, 5);
      hold_nr = 20;
      step();
      g = go_cyc;
      repeat (5) step();
      go_req = 1'b1;
      wait_done("hold");
      check_val("hold_first_tx", first_tx_cyc - g, 20);
      check_seq("hold", 1'b1, ch);
      repeat (10) step();
      check_val("hold_go_ignored_busy", a_busy, 0);
      check_val("hold_go_ignored_tx", tx_log.size(), 3);

      // reset in the middle of STORE, at byte 5
      start_seq(1'b1, 8'h5A, 4);
      for (int i = 0; i < 400 && !(a_mem_we && a_mem_addr == 8'h05); i++) step();
      check_val("rst_reached_b5", {a_mem_we, a_mem_addr}, {1'b1, 8'h05});
      n_rst = 1'b0;
      spi_cnt = -1; puf_cnt = -1;
      #1;
      check_val("rst_async_outs", outs_a(), 0);
      step();
      check_val("rst_next_outs", outs_a(), 0);
      check_val("rst_next_we_b", b_mem_we, 0);
      n_rst = 1'b1;
      ch = 8'($urandom);
      start_seq(1'b1, ch, 7);
      wait_done("after_rst");
      check_seq("after_rst", 1'b1, ch);

      // PUF never finishes
      start_seq(1'b1, 8'hC3, -1);
`ifdef PUF_AUTH_TIMEOUT_EN
      wait_done("tmo");
      check_seq("tmo", 1'b0, 8'hC3);
      check_val("tmo_latency", stat_cyc - start_cyc, 16);
`else
      repeat (200) step();
      check_val("hang_busy", a_busy, 1);
      check_val("hang_tx_n", tx_log.size(), 2);
      check_val("hang_result", n_pass + n_fail, 0);
      check_val("hang_chal", a_puf_challenge, 8'hC3);
      do_reset();
      check_val("hang_recover", outs_a(), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_errors);
      $finish;
   end

endmodule
